// File: rtl/dequant_stream.sv
`default_nettype none
// ============================================================================
// Module   : dequant_stream
// Purpose  : Streaming dequantizer. Computes
//                dout = sat(round((din * scale) >>> shift))
//            It uses a runtime scale and shift, a valid/ready handshake with
//            backpressure, a two-stage pipeline and burst tracking.
//            Scale and shift are sampled on the first beat of each burst and
//            held for the rest of it.
// Ports    : clk_i        - clock, rising edge
//            rstn_i       - asynchronous active-low reset
//            cfg_scale_i  - signed scale, sampled on beat 0 of a burst
//            cfg_shift_i  - right-shift amount, sampled with cfg_scale_i
//            din_i        - signed quantized input
//            valid_i      - input valid
//            ready_o      - input ready (low only while the output is stalled)
//            dout_o       - signed, saturated dequantized output
//            valid_o      - output valid
//            ready_i      - downstream ready
//            sat_o        - dout_o was clipped
//            last_o       - dout_o is the final beat of its burst
//            done_o       - one-cycle pulse after a last beat hands off
// Revision : 1.0 - initial release
// ============================================================================
module dequant_stream #(
    parameter int DIN_W     = 32,
    parameter int SCALE_W   = 16,
    parameter int SHIFT_W   = 6,
    parameter int DOUT_W    = 32,
    parameter int BURST_LEN = 8
) (
    input  logic               clk_i,
    input  logic               rstn_i,
    input  logic [SCALE_W-1:0] cfg_scale_i,
    input  logic [SHIFT_W-1:0] cfg_shift_i,
    input  logic [DIN_W-1:0]   din_i,
    input  logic               valid_i,
    output logic               ready_o,
    output logic [DOUT_W-1:0]  dout_o,
    output logic               valid_o,
    input  logic               ready_i,
    output logic               sat_o,
    output logic               last_o,
    output logic               done_o
);

    localparam int P     = DIN_W + SCALE_W;
    localparam int CNT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BURST_LEN - 1);
    localparam logic [P:0]       RND_ONE  = (P+1)'(1);
    localparam logic [31:0]      MAX_SHIFT = 32'(P - 1);
    localparam logic [DOUT_W-1:0] DOUT_MAX = {1'b0, {(DOUT_W-1){1'b1}}};
    localparam logic [DOUT_W-1:0] DOUT_MIN = {1'b1, {(DOUT_W-1){1'b0}}};

    // Burst tracking and latched configuration
    logic [CNT_W-1:0]   in_cnt_q, in_cnt_d;
    logic [SCALE_W-1:0] scale_q, scale_d;
    logic [SHIFT_W-1:0] shift_q, shift_d;

    // Stage 1: product
    logic               s1_valid_q, s1_valid_d;
    logic [P-1:0]       s1_prod_q, s1_prod_d;
    logic [SHIFT_W-1:0] s1_shift_q, s1_shift_d;
    logic               s1_last_q, s1_last_d;

    // Stage 2: rounded and saturated output
    logic               out_valid_q, out_valid_d;
    logic [DOUT_W-1:0]  dout_q, dout_d;
    logic               sat_q, sat_d;
    logic               last_q, last_d;
    logic               done_q, done_d;

    // Handshake
    logic stall;
    logic advance;
    logic accept;
    logic first_beat;
    logic is_last;

    assign stall      = out_valid_q && !ready_i;
    assign advance    = !stall;
    assign accept     = valid_i && advance;
    assign first_beat = (in_cnt_q == '0);
    assign is_last    = (in_cnt_q == LAST_CNT);

    // Stage-1 arithmetic. Both operands are sign-extended to P bits so the
    // low P bits of the product are the exact signed result.
    logic [SCALE_W-1:0] eff_scale;
    logic [SHIFT_W-1:0] eff_shift;
    logic signed [P-1:0] din_ext;
    logic signed [P-1:0] scale_ext;
    logic signed [P-1:0] prod;

    assign eff_scale = first_beat ? cfg_scale_i : scale_q;
    assign eff_shift = first_beat ? cfg_shift_i : shift_q;
    assign din_ext   = $signed({{SCALE_W{din_i[DIN_W-1]}}, din_i});
    assign scale_ext = $signed({{DIN_W{eff_scale[SCALE_W-1]}}, eff_scale});
    assign prod      = din_ext * scale_ext;

    // Stage-2 arithmetic. The rounding add is one bit wider than the product,
    // so the largest product plus the half-LSB term cannot wrap.
    logic [31:0]         shift_amt;
    logic [P:0]          rnd;
    logic signed [P:0]   sum;
    logic signed [P:0]   r;
    logic                pos_ovf;
    logic                neg_ovf;
    logic [DOUT_W-1:0]   dout_sat;
    logic                sat_w;

    always_comb begin
        shift_amt = 32'(s1_shift_q);
        if (shift_amt > MAX_SHIFT) begin
            shift_amt = MAX_SHIFT;
        end
        rnd = '0;
        if (shift_amt != 32'd0) begin
            rnd = RND_ONE << (shift_amt - 32'd1);
        end
        sum = $signed({s1_prod_q[P-1], s1_prod_q}) + $signed(rnd);
        r   = sum >>> shift_amt;

        // Out of range when the bits above the output sign bit are not
        // all copies of the overall sign.
        pos_ovf = !r[P] && (|r[P:DOUT_W-1]);
        neg_ovf =  r[P] && !(&r[P:DOUT_W-1]);

        dout_sat = r[DOUT_W-1:0];
        sat_w    = 1'b0;
        if (pos_ovf) begin
            dout_sat = DOUT_MAX;
            sat_w    = 1'b1;
        end else if (neg_ovf) begin
            dout_sat = DOUT_MIN;
            sat_w    = 1'b1;
        end
    end

    // Next-state logic
    always_comb begin
        in_cnt_d    = in_cnt_q;
        scale_d     = scale_q;
        shift_d     = shift_q;
        s1_valid_d  = s1_valid_q;
        s1_prod_d   = s1_prod_q;
        s1_shift_d  = s1_shift_q;
        s1_last_d   = s1_last_q;
        out_valid_d = out_valid_q;
        dout_d      = dout_q;
        sat_d       = sat_q;
        last_d      = last_q;
        done_d      = out_valid_q && ready_i && last_q;

        if (accept) begin
            in_cnt_d   = is_last ? '0 : in_cnt_q + CNT_W'(1);
            if (first_beat) begin
                scale_d = cfg_scale_i;
                shift_d = cfg_shift_i;
            end
            s1_prod_d  = prod;
            s1_shift_d = eff_shift;
            s1_last_d  = is_last;
        end

        // Both stages move together; a stall freezes everything.
        if (advance) begin
            s1_valid_d  = accept;
            out_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                dout_d = dout_sat;
                sat_d  = sat_w;
                last_d = s1_last_q;
            end else begin
                sat_d  = 1'b0;
                last_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            in_cnt_q    <= '0;
            scale_q     <= '0;
            shift_q     <= '0;
            s1_valid_q  <= 1'b0;
            s1_prod_q   <= '0;
            s1_shift_q  <= '0;
            s1_last_q   <= 1'b0;
            out_valid_q <= 1'b0;
            dout_q      <= '0;
            sat_q       <= 1'b0;
            last_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            in_cnt_q    <= in_cnt_d;
            scale_q     <= scale_d;
            shift_q     <= shift_d;
            s1_valid_q  <= s1_valid_d;
            s1_prod_q   <= s1_prod_d;
            s1_shift_q  <= s1_shift_d;
            s1_last_q   <= s1_last_d;
            out_valid_q <= out_valid_d;
            dout_q      <= dout_d;
            sat_q       <= sat_d;
            last_q      <= last_d;
            done_q      <= done_d;
        end
    end

    assign ready_o = advance;
    assign dout_o  = dout_q;
    assign valid_o = out_valid_q;
    assign sat_o   = sat_q;
    assign last_o  = last_q;
    assign done_o  = done_q;

endmodule
`default_nettype wire
